// File: rtl/aes_ark_pkg.sv
// Shared constants for the AddRoundKey block: FSM state codes, row count and
// default parameter values.
package aes_ark_pkg;

  localparam int ROWS                   = 4;
  localparam int COL_W                  = 4;
  localparam int NB_DEF                 = 4;
  localparam int DATA_W_DEF             = 32;
  localparam int ST_AW_DEF              = 5;
  localparam int KEY_AW_DEF             = 9;
  localparam int KEY_ROW_STRIDE_DEF     = 120;
  localparam int MAX_ROUND_DEF          = 14;

  typedef logic [2:0] ark_state_t;

  localparam ark_state_t S_IDLE  = 3'd0;
  localparam ark_state_t S_CHECK = 3'd1;
  localparam ark_state_t S_RD01  = 3'd2;
  localparam ark_state_t S_RD23  = 3'd3;
  localparam ark_state_t S_WR01  = 3'd4;
  localparam ark_state_t S_WR23  = 3'd5;

endpackage

// File: rtl/aes_ark_addr_gen.sv
// Combinational address generator: state and key addresses for one row pair
// (rows 0/1 or rows 2/3) of the current column.
module aes_ark_addr_gen
  import aes_ark_pkg::*;
#(
  parameter int NB             = NB_DEF,
  parameter int ST_AW          = ST_AW_DEF,
  parameter int KEY_AW         = KEY_AW_DEF,
  parameter int KEY_ROW_STRIDE = KEY_ROW_STRIDE_DEF
) (
  input  logic [COL_W-1:0]  col,
  input  logic [3:0]        n_reg,
  input  logic              hi_pair,
  output logic [ST_AW-1:0]  st_addr0,
  output logic [ST_AW-1:0]  st_addr1,
  output logic [KEY_AW-1:0] key_addr0,
  output logic [KEY_AW-1:0] key_addr1
);

  logic [31:0] row0;
  logic [31:0] row1;
  logic [31:0] key_col;

  assign row0    = {30'd0, hi_pair, 1'b0};
  assign row1    = {30'd0, hi_pair, 1'b1};
  // Round offset plus column is common to both rows of the pair.
  assign key_col = 32'(n_reg) * 32'(NB) + 32'(col);

  always_comb begin
    st_addr0  = ST_AW'(32'(col) * 32'd4 + row0);
    st_addr1  = ST_AW'(32'(col) * 32'd4 + row1);
    key_addr0 = KEY_AW'(row0 * 32'(KEY_ROW_STRIDE) + key_col);
    key_addr1 = KEY_AW'(row1 * 32'(KEY_ROW_STRIDE) + key_col);
  end

endmodule

// File: rtl/aes_add_round_key_param.sv
// AES AddRoundKey over an NB-column state held in external dual-port memory;
// each column takes five cycles (check, two reads, two writes).
module aes_add_round_key_param
  import aes_ark_pkg::*;
#(
  parameter int NB             = NB_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ST_AW          = ST_AW_DEF,
  parameter int KEY_AW         = KEY_AW_DEF,
  parameter int KEY_ROW_STRIDE = KEY_ROW_STRIDE_DEF,
  parameter int MAX_ROUND      = MAX_ROUND_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              ap_err,
  input  logic [3:0]        n,
  output logic [ST_AW-1:0]  statemt_address0,
  output logic              statemt_ce0,
  output logic              statemt_we0,
  output logic [DATA_W-1:0] statemt_d0,
  input  logic [DATA_W-1:0] statemt_q0,
  output logic [ST_AW-1:0]  statemt_address1,
  output logic              statemt_ce1,
  output logic              statemt_we1,
  output logic [DATA_W-1:0] statemt_d1,
  input  logic [DATA_W-1:0] statemt_q1,
  output logic [KEY_AW-1:0] key_address0,
  output logic              key_ce0,
  input  logic [7:0]        key_q0,
  output logic [KEY_AW-1:0] key_address1,
  output logic              key_ce1,
  input  logic [7:0]        key_q1
);

  ark_state_t        state;
  logic [COL_W-1:0]  col;
  logic [3:0]        n_reg;
  logic [DATA_W-1:0] x0_p1, x1_p1, x2_p1, x3_p1;
  logic              n_bad, last_col, hi_pair;

  function automatic logic [DATA_W-1:0] ark_xor(input logic [DATA_W-1:0] s,
                                                input logic [7:0]        k);
    return s ^ {{(DATA_W-8){1'b0}}, k};
  endfunction

  assign n_bad    = n_reg > 4'(MAX_ROUND);
  assign last_col = col == COL_W'(NB);
  assign hi_pair  = (state == S_RD23) || (state == S_WR23);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= S_IDLE;
      col   <= '0;
      n_reg <= '0;
      x0_p1 <= '0;
      x1_p1 <= '0;
      x2_p1 <= '0;
      x3_p1 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            n_reg <= n;
            col   <= '0;
            state <= S_CHECK;
          end
        end
        S_CHECK: state <= (n_bad || last_col) ? S_IDLE : S_RD01;
        S_RD01:  state <= S_RD23;
        // Stage boundary: rows 0/1 read data combined with key bytes.
        S_RD23: begin
          x0_p1 <= ark_xor(statemt_q0, key_q0);
          x1_p1 <= ark_xor(statemt_q1, key_q1);
          state <= S_WR01;
        end
        // Stage boundary: rows 2/3 combined while rows 0/1 are written back.
        S_WR01: begin
          x2_p1 <= ark_xor(statemt_q0, key_q0);
          x3_p1 <= ark_xor(statemt_q1, key_q1);
          state <= S_WR23;
        end
        S_WR23: begin
          col   <= col + 1'b1;
          state <= S_CHECK;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  aes_ark_addr_gen #(
    .NB             (NB),
    .ST_AW          (ST_AW),
    .KEY_AW         (KEY_AW),
    .KEY_ROW_STRIDE (KEY_ROW_STRIDE)
  ) u_addr_gen (
    .col       (col),
    .n_reg     (n_reg),
    .hi_pair   (hi_pair),
    .st_addr0  (statemt_address0),
    .st_addr1  (statemt_address1),
    .key_addr0 (key_address0),
    .key_addr1 (key_address1)
  );

  assign ap_idle  = state == S_IDLE;
  assign ap_done  = (state == S_CHECK) && (n_bad || last_col);
  assign ap_ready = ap_done;
  assign ap_err   = (state == S_CHECK) && n_bad;

  assign statemt_ce0 = (state == S_RD01) || (state == S_RD23) ||
                       (state == S_WR01) || (state == S_WR23);
  assign statemt_ce1 = statemt_ce0;
  assign statemt_we0 = (state == S_WR01) || (state == S_WR23);
  assign statemt_we1 = statemt_we0;
  assign key_ce0     = (state == S_RD01) || (state == S_RD23);
  assign key_ce1     = key_ce0;
  assign statemt_d0  = (state == S_WR01) ? x0_p1 : x2_p1;
  assign statemt_d1  = (state == S_WR01) ? x1_p1 : x3_p1;

endmodule
